regs_wb_arbiter: RTL and testbench

REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

---
 rtl/regs_wb_arbiter.sv | 94 +++++++++
 tb/tb_regs_wb_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/regs_wb_arbiter.sv
// Two-requester (EX, LSU) register-file writeback arbiter with starvation
// protection for the LSU and a single registered write port.
module regs_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [63:0] ex_wdata_i,
    output logic        ex_ready_o,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [63:0] lsu_wdata_i,
    output logic        lsu_ready_o,
    output logic        reg_wen_o,
    output logic [4:0]  reg_waddr_o,
    output logic [63:0] reg_wdata_o,
    output logic        starve_o
);

    typedef enum logic {
        PRI_EX,
        PRI_LSU
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        reg_wen_q, reg_wen_d;
    logic [4:0]  reg_waddr_q, reg_waddr_d;
    logic [63:0] reg_wdata_q, reg_wdata_d;

    logic        ex_grant;
    logic        lsu_grant;
    logic        xfer;
    logic [4:0]  sel_waddr;
    logic [63:0] sel_wdata;

    // A lone requester always wins; state only breaks ties. Reset blocks grants.
    always_comb begin
        ex_grant  = rst && ex_valid_i  && (!lsu_valid_i || (state_q == PRI_EX));
        lsu_grant = rst && lsu_valid_i && (!ex_valid_i  || (state_q == PRI_LSU));
        xfer      = ex_grant || lsu_grant;
        sel_waddr = lsu_grant ? lsu_waddr_i : ex_waddr_i;
        sel_wdata = lsu_grant ? lsu_wdata_i : ex_wdata_i;
    end

    always_comb begin
        cnt_d = '0;
        if (lsu_valid_i && !lsu_grant) begin
            cnt_d = (cnt_q == 4'hF) ? cnt_q : 4'(cnt_q + 4'd1);
        end

        state_d = state_q;
        case (state_q)
            PRI_EX:  if (cnt_d >= LIMIT) state_d = PRI_LSU;
            PRI_LSU: if (lsu_grant)      state_d = PRI_EX;
            default: state_d = PRI_EX;
        endcase
    end

    // x0 writes still handshake but never raise the write enable.
    always_comb begin
        reg_wen_d   = xfer && (sel_waddr != 5'd0);
        reg_waddr_d = xfer ? sel_waddr : reg_waddr_q;
        reg_wdata_d = xfer ? sel_wdata : reg_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= PRI_EX;
            cnt_q       <= '0;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign ex_ready_o  = ex_grant;
    assign lsu_ready_o = lsu_grant;
    assign reg_wen_o   = reg_wen_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign starve_o    = (state_q == PRI_LSU);

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter: per-cycle vector table on a
// STARVE_LIMIT=3 instance plus a saturation run on a STARVE_LIMIT=15 instance.
module tb_regs_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic [4:0]  ex_waddr_i;
    logic [63:0] ex_wdata_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_waddr_i;
    logic [63:0] lsu_wdata_i;

    logic        ex_ready_o, lsu_ready_o, reg_wen_o, starve_o;
    logic [4:0]  reg_waddr_o;
    logic [63:0] reg_wdata_o;

    logic        ex_ready_15, lsu_ready_15, reg_wen_15, starve_15;
    logic [4:0]  reg_waddr_15;
    logic [63:0] reg_wdata_15;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regs_wb_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(ex_ready_o),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_ready_o(lsu_ready_o),
        .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .starve_o(starve_o)
    );

    regs_wb_arbiter #(.STARVE_LIMIT(15)) dut15 (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(ex_ready_15),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_ready_o(lsu_ready_15),
        .reg_wen_o(reg_wen_15), .reg_waddr_o(reg_waddr_15), .reg_wdata_o(reg_wdata_15),
        .starve_o(starve_15)
    );

    typedef struct {
        logic        rst;
        logic        exv;
        logic [4:0]  exa;
        logic [63:0] exd;
        logic        lv;
        logic [4:0]  la;
        logic [63:0] ld;
        logic        e_exr;
        logic        e_lr;
        logic        e_st;
        logic        e_wen;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
        logic        chk_d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic exv, logic [4:0] exa, logic [63:0] exd,
                                logic lv, logic [4:0] la, logic [63:0] ld,
                                logic e_exr, logic e_lr, logic e_st,
                                logic e_wen, logic [4:0] e_wa, logic [63:0] e_wd,
                                logic chk_d);
        vec_t v;
        v.rst = r; v.exv = exv; v.exa = exa; v.exd = exd;
        v.lv = lv; v.la = la; v.ld = ld;
        v.e_exr = e_exr; v.e_lr = e_lr; v.e_st = e_st;
        v.e_wen = e_wen; v.e_wa = e_wa; v.e_wd = e_wd; v.chk_d = chk_d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic exv, input logic [4:0] exa,
                         input logic [63:0] exd, input logic lv, input logic [4:0] la,
                         input logic [63:0] ld);
        rst = r; ex_valid_i = exv; ex_waddr_i = exa; ex_wdata_i = exd;
        lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
    endtask

    initial begin
        int grants;
        // rst exv exa exd  lv la ld | exr lr st | wen wa wd | chk_d
        vecs.push_back(mk(0, 1, 3, 64'h55, 1, 2, 64'h66, 0, 0, 0, 0, 0, 64'h0, 1));           // ready blocked in reset
        vecs.push_back(mk(1, 1, 5, 64'hDEAD_BEEF, 0, 0, 0, 1, 0, 0, 1, 5, 64'hDEAD_BEEF, 1)); // single EX
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 64'hDEAD_BEEF, 1));             // idle holds
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 64'h1234, 0, 1, 0, 0, 0, 0, 0));                  // x0 drop
        vecs.push_back(mk(1, 1, 1, 64'h11, 1, 2, 64'h22, 1, 0, 0, 1, 1, 64'h11, 1));          // contention
        vecs.push_back(mk(1, 1, 1, 64'h11, 1, 2, 64'h22, 1, 0, 0, 1, 1, 64'h11, 1));
        vecs.push_back(mk(1, 1, 1, 64'h11, 1, 2, 64'h22, 1, 0, 0, 1, 1, 64'h11, 1));
        vecs.push_back(mk(1, 1, 1, 64'h11, 1, 2, 64'h22, 0, 1, 1, 1, 2, 64'h22, 1));
        vecs.push_back(mk(1, 1, 1, 64'h11, 1, 2, 64'h22, 1, 0, 0, 1, 1, 64'h11, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h11, 1));
        vecs.push_back(mk(1, 1, 7, 64'hAA, 1, 7, 64'hBB, 1, 0, 0, 1, 7, 64'hAA, 1));          // same rd
        vecs.push_back(mk(1, 0, 0, 0, 1, 7, 64'hBB, 0, 1, 0, 1, 7, 64'hBB, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 64'hBB, 1));
        vecs.push_back(mk(1, 1, 4, 64'h44, 0, 0, 0, 1, 0, 0, 1, 4, 64'h44, 1));               // back-to-back
        vecs.push_back(mk(1, 0, 0, 0, 1, 6, 64'h66, 0, 1, 0, 1, 6, 64'h66, 1));
        vecs.push_back(mk(1, 1, 8, 64'h88, 0, 0, 0, 1, 0, 0, 1, 8, 64'h88, 1));
        vecs.push_back(mk(0, 1, 3, 64'h33, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 1));                // reset mid-write
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 1));
        vecs.push_back(mk(1, 1, 1, 64'h11, 1, 2, 64'h22, 1, 0, 0, 1, 1, 64'h11, 1));          // counter restarts at 0
        vecs.push_back(mk(1, 1, 1, 64'h11, 1, 2, 64'h22, 1, 0, 0, 1, 1, 64'h11, 1));
        vecs.push_back(mk(1, 1, 1, 64'h11, 1, 2, 64'h22, 1, 0, 0, 1, 1, 64'h11, 1));
        vecs.push_back(mk(1, 1, 1, 64'h11, 0, 0, 0, 1, 0, 1, 1, 1, 64'h11, 1));               // lone EX in PRI_LSU
        vecs.push_back(mk(1, 0, 0, 0, 1, 2, 64'h22, 0, 1, 1, 1, 2, 64'h22, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 64'h22, 1));

        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].exv, vecs[i].exa, vecs[i].exd,
                  vecs[i].lv, vecs[i].la, vecs[i].ld);
            #1;
            chk($sformatf("row%0d ex_ready", i), 64'(ex_ready_o), 64'(vecs[i].e_exr));
            chk($sformatf("row%0d lsu_ready", i), 64'(lsu_ready_o), 64'(vecs[i].e_lr));
            chk($sformatf("row%0d starve", i), 64'(starve_o), 64'(vecs[i].e_st));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d reg_wen", i), 64'(reg_wen_o), 64'(vecs[i].e_wen));
            if (vecs[i].chk_d) begin
                chk($sformatf("row%0d reg_waddr", i), 64'(reg_waddr_o), 64'(vecs[i].e_wa));
                chk($sformatf("row%0d reg_wdata", i), reg_wdata_o, vecs[i].e_wd);
            end
        end

        // Saturation: LIMIT=15, both valid for 20 cycles -> one LSU grant at cycle 15.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1, 1, 1, 64'h11, 1, 2, 64'h22);
            #1;
            chk($sformatf("sat%0d lsu_ready", c), 64'(lsu_ready_15), (c == 15) ? 64'd1 : 64'd0);
            chk($sformatf("sat%0d starve", c), 64'(starve_15), (c == 15) ? 64'd1 : 64'd0);
            if (lsu_ready_15) grants++;
            @(negedge clk);
        end
        chk("sat lsu_grant_count", 64'(grants), 64'd1);

        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
